avalon_cmd_master: RTL and testbench

// Avalon-MM master that runs one command on our command/status register slave (e.g. new_component).
// On a user start pulse it does five steps: write the operand, write the command word, clear

---
 rtl/avalon_cmd_pkg.sv | 23 ++
 rtl/avalon_cmd_delay.sv | 33 +++
 rtl/avalon_cmd_master.sv | 186 ++++++++++++++++++
 tb/tb_avalon_cmd_master.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_cmd_pkg.sv
// Shared addresses, command codes and FSM state encoding for the Avalon command master.
package avalon_cmd_pkg;

  localparam logic [7:0]  ADDR_COMMAND_DEF = 8'd1;
  localparam logic [7:0]  ADDR_STATUS_DEF  = 8'd2;
  localparam logic [7:0]  ADDR_INP_DEF     = 8'd3;
  localparam logic [7:0]  ADDR_OUTP_DEF    = 8'd4;

  localparam logic [31:0] FLIP_BITS_CMD    = 32'd1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_INP,
    S_WR_CMD,
    S_SETTLE,
    S_CLR_STAT,
    S_RD_STAT,
    S_GAP,
    S_RD_OUTP,
    S_DONE
  } state_e;

endpackage

// File: rtl/avalon_cmd_delay.sv
// Loadable down-counter with a zero flag; times the settle and poll-gap idle periods.
module avalon_cmd_delay #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/avalon_cmd_master.sv
// Avalon-MM master: writes operand and command, clears status, polls for done, reads the result.
module avalon_cmd_master
  import avalon_cmd_pkg::*;
#(
  parameter logic [7:0]  ADDR_COMMAND  = ADDR_COMMAND_DEF,
  parameter logic [7:0]  ADDR_STATUS   = ADDR_STATUS_DEF,
  parameter logic [7:0]  ADDR_INP      = ADDR_INP_DEF,
  parameter logic [7:0]  ADDR_OUTP     = ADDR_OUTP_DEF,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned POLL_GAP      = 2,
  parameter int unsigned MAX_POLLS     = 255
) (
  input  logic        clock_sink_clk,
  input  logic        reset_sink_reset,
  input  logic        start,
  input  logic [31:0] op_cmd,
  input  logic [31:0] op_inp,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        error,
  output logic [7:0]  avalon_master_address,
  output logic        avalon_master_read,
  input  logic [31:0] avalon_master_readdata,
  output logic        avalon_master_write,
  output logic [31:0] avalon_master_writedata,
  input  logic        avalon_master_waitrequest
);

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD    = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

  state_e      state_q;
  logic        busy_q, done_q, error_q, read_q, write_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q, result_q, cmd_q;
  logic [15:0] polls_q;

  logic        xfer_ok, stat_done, more_polls;
  logic [16:0] polls_next;
  logic        dly_load, dly_zero;
  logic [15:0] dly_val;

  assign xfer_ok    = !avalon_master_waitrequest;
  assign stat_done  = avalon_master_readdata[0];
  assign polls_next = {1'b0, polls_q} + 17'd1;
  assign more_polls = polls_next < 17'(MAX_POLLS);

  // Delay is loaded on the completing edge so the idle state's length is exact.
  always_comb begin
    dly_load = 1'b0;
    dly_val  = '0;
    if (state_q == S_WR_CMD && xfer_ok) begin
      dly_load = 1'b1;
      dly_val  = SETTLE_LOAD;
    end else if (state_q == S_RD_STAT && xfer_ok && !stat_done) begin
      dly_load = 1'b1;
      dly_val  = GAP_LOAD;
    end
  end

  avalon_cmd_delay #(.WIDTH(16)) u_delay (
    .clk_i      (clock_sink_clk),
    .rst_i      (reset_sink_reset),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .zero_o     (dly_zero)
  );

  always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      cmd_q    <= '0;
      polls_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cmd_q   <= op_cmd;
            error_q <= 1'b0;
            polls_q <= '0;
            busy_q  <= 1'b1;
            write_q <= 1'b1;
            addr_q  <= ADDR_INP;
            wdata_q <= op_inp;
            state_q <= S_WR_INP;
          end
        end
        S_WR_INP: begin
          if (xfer_ok) begin
            addr_q  <= ADDR_COMMAND;
            wdata_q <= cmd_q;
            state_q <= S_WR_CMD;
          end
        end
        S_WR_CMD: begin
          if (xfer_ok) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (dly_zero) begin
            write_q <= 1'b1;
            addr_q  <= ADDR_STATUS;
            wdata_q <= '0;
            state_q <= S_CLR_STAT;
          end
        end
        S_CLR_STAT: begin
          if (xfer_ok) begin
            write_q <= 1'b0;
            read_q  <= 1'b1;
            state_q <= S_RD_STAT;
          end
        end
        S_RD_STAT: begin
          if (xfer_ok) begin
            polls_q <= polls_next[15:0];
            if (stat_done) begin
              addr_q  <= ADDR_OUTP;
              state_q <= S_RD_OUTP;
            end else if (more_polls) begin
              if (POLL_GAP != 0) begin
                read_q  <= 1'b0;
                state_q <= S_GAP;
              end
            end else begin
              read_q  <= 1'b0;
              addr_q  <= '0;
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_GAP: begin
          if (dly_zero) begin
            read_q  <= 1'b1;
            state_q <= S_RD_STAT;
          end
        end
        S_RD_OUTP: begin
          if (xfer_ok) begin
            read_q   <= 1'b0;
            addr_q   <= '0;
            result_q <= avalon_master_readdata;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          read_q  <= 1'b0;
          write_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy                    = busy_q;
  assign done                    = done_q;
  assign result                  = result_q;
  assign error                   = error_q;
  assign avalon_master_address   = addr_q;
  assign avalon_master_read      = read_q;
  assign avalon_master_write     = write_q;
  assign avalon_master_writedata = wdata_q;

endmodule

// File: tb/tb_avalon_cmd_master.sv
// Bench for avalon_cmd_master against a behavioural command/status slave with optional stalls.
module tb_avalon_cmd_master;
  import avalon_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_cmd = '0;
  logic [31:0] op_inp = '0;
  logic        busy, done, error, m_read, m_write, waitreq;
  logic [31:0] result, rdata, wdata;
  logic [7:0]  addr;

  always #5 clk = ~clk;

  avalon_cmd_master #(.MAX_POLLS(4)) dut (
    .clock_sink_clk            (clk),
    .reset_sink_reset          (rst),
    .start                     (start),
    .op_cmd                    (op_cmd),
    .op_inp                    (op_inp),
    .busy                      (busy),
    .done                      (done),
    .result                    (result),
    .error                     (error),
    .avalon_master_address     (addr),
    .avalon_master_read        (m_read),
    .avalon_master_readdata    (rdata),
    .avalon_master_write       (m_write),
    .avalon_master_writedata   (wdata),
    .avalon_master_waitrequest (waitreq)
  );

  // Slave model: command write starts a comp_lat countdown, then done=1 and outp is updated.
  logic [31:0] s_cmd = '0, s_inp = '0, s_outp = '0;
  logic        s_done = 1'b0;
  int          s_cnt = 0;
  int          comp_lat = 2;
  bit          stuck = 1'b0;
  bit          ws_en = 1'b0;
  int          ws_cnt = 0;

  assign waitreq = ws_en && (m_read || m_write) && (ws_cnt < 3);
  assign rdata   = (addr == 8'd2) ? {31'd0, s_done & ~stuck} :
                   (addr == 8'd4) ? s_outp : 32'd0;

  always @(posedge clk) begin
    if (m_write && !waitreq) begin
      case (addr)
        8'd1:    begin s_cmd <= wdata; s_cnt <= comp_lat; end
        8'd2:    s_done <= 1'b0;
        8'd3:    s_inp <= wdata;
        default: ;
      endcase
    end
    if (s_cnt != 0 && !(m_write && !waitreq && addr == 8'd1)) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) begin
        s_done <= 1'b1;
        s_outp <= (s_cmd == FLIP_BITS_CMD) ? ~s_inp : s_inp;
      end
    end
    if (ws_en && (m_read || m_write)) ws_cnt <= waitreq ? ws_cnt + 1 : 0;
  end

  typedef struct { logic [31:0] res; logic err; } exp_t;
  typedef struct { logic wr; logic [7:0] a; logic [31:0] d; } xfer_t;

  exp_t  exp_q[$];
  xfer_t bus_log[$];
  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  logic [31:0] last_res = '0;

  bit    hold_q = 1'b0;
  logic [41:0] held;
  exp_t  e;

  always @(negedge clk) begin
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: result=%h error=%b with nothing expected", result, error);
        end else begin
          e = exp_q.pop_front();
          if (result !== e.res || error !== e.err) begin
            errors++;
            $display("FAIL scoreboard: got result=%h error=%b, want result=%h error=%b",
                     result, error, e.res, e.err);
          end
        end
      end
      if (m_read || m_write) begin
        checks++;
        if (m_read && m_write) begin
          errors++;
          $display("FAIL rw_exclusive: read=%b write=%b, want not both", m_read, m_write);
        end
      end
      if (hold_q) begin
        checks++;
        if ({m_read, m_write, addr, wdata} !== held) begin
          errors++;
          $display("FAIL hold_stable: got %h, want %h", {m_read, m_write, addr, wdata}, held);
        end
      end
      hold_q = (m_read || m_write) && waitreq;
      held   = {m_read, m_write, addr, wdata};
      if ((m_read || m_write) && !waitreq)
        bus_log.push_back('{m_write, addr, m_write ? wdata : rdata});
    end
  end

  // Called at a negedge; start is seen by the DUT at the following posedge (cycle 0).
  task automatic pulse_start(input logic [31:0] inp, input logic [31:0] cmd);
    op_inp = inp;
    op_cmd = cmd;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic expect_result(input logic [31:0] res, input logic err);
    exp_q.push_back('{res, err});
    if (!err) last_res = res;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 1;
    while (!done && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, want done", budget);
    end
  endtask

  task automatic run_op(input logic [31:0] inp, input logic [31:0] res, input logic err,
                        input int budget, output int lat);
    expect_result(res, err);
    pulse_start(inp, FLIP_BITS_CMD);
    wait_done(budget, lat);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, error, m_read, m_write, addr, wdata, result} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b rd=%b wr=%b addr=%h wd=%h res=%h, want all 0",
               busy, done, error, m_read, m_write, addr, wdata, result);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (m_read !== 1'b0 || m_write !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet: cycle %0d rd=%b wr=%b busy=%b, want 0", i, m_read, m_write, busy);
      end
    end
  endtask

  task automatic test_basic;
    int lat;
    int d0;
    bit        ew[5];
    logic [7:0]  ea[5];
    logic [31:0] ed[5];
    ew = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ea = '{8'd3, 8'd1, 8'd2, 8'd2, 8'd4};
    ed = '{32'h0000_FFFF, 32'd1, 32'd0, 32'd1, 32'hFFFF_0000};
    comp_lat = 2;
    bus_log.delete();
    d0 = done_cnt;
    run_op(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 50, lat);
    repeat (5) @(negedge clk);
    checks++;
    if (lat != 7) begin
      errors++;
      $display("FAIL min_latency: got %0d cycles, want 7", lat);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL done_once: got %0d pulses, want 1", done_cnt - d0);
    end
    checks++;
    if (bus_log.size() != 5) begin
      errors++;
      $display("FAIL trace_len: got %0d transfers, want 5", bus_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (bus_log[i].wr !== ew[i] || bus_log[i].a !== ea[i] || bus_log[i].d !== ed[i]) begin
          errors++;
          $display("FAIL trace[%0d]: got wr=%b a=%h d=%h, want wr=%b a=%h d=%h", i,
                   bus_log[i].wr, bus_log[i].a, bus_log[i].d, ew[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    comp_lat = 6;
    run_op(32'h1234_5678, 32'hEDCB_A987, 1'b0, 60, lat);
    run_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 60, lat);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout;
    int lat;
    int reads;
    comp_lat = 2;
    stuck = 1'b1;
    bus_log.delete();
    run_op(32'hA5A5_A5A5, last_res, 1'b1, 100, lat);
    reads = 0;
    foreach (bus_log[i]) if (!bus_log[i].wr && bus_log[i].a == 8'd2) reads++;
    checks++;
    if (reads != 4) begin
      errors++;
      $display("FAIL poll_count: got %0d status reads, want 4", reads);
    end
    stuck = 1'b0;
    expect_result(32'h5A5A_0000, 1'b0);
    pulse_start(32'hA5A5_FFFF, FLIP_BITS_CMD);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: got error=%b after start, want 0", error);
    end
    wait_done(50, lat);
    @(negedge clk);
  endtask

  task automatic test_waitrequest;
    int lat;
    comp_lat = 5;
    ws_en = 1'b1;
    run_op(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 100, lat);
    ws_en = 1'b0;
    checks++;
    if (lat != 22) begin
      errors++;
      $display("FAIL stall_latency: got %0d cycles, want 22", lat);
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    int d0;
    comp_lat = 2;
    d0 = done_cnt;
    expect_result(32'hFF00_FF00, 1'b0);
    pulse_start(32'h00FF_00FF, FLIP_BITS_CMD);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_high: got busy=%b, want 1", busy);
    end
    @(negedge clk);
    op_inp = 32'hDEAD_BEEF;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(50, lat);
    lat += 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL start_ignored: got busy=%b pulses=%0d, want busy=0 pulses=1",
               busy, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int lat;
    comp_lat = 2;
    stuck = 1'b1;
    pulse_start(32'h1111_1111, FLIP_BITS_CMD);
    n = 0;
    while (!(m_read && addr == 8'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(m_read && addr == 8'd2)) begin
      errors++;
      $display("FAIL poll_reach: no status read within 50 cycles, want one");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, error, m_read, m_write, addr, wdata, result} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b rd=%b wr=%b addr=%h res=%h, want all 0",
               busy, m_read, m_write, addr, result);
    end
    last_res = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stuck = 1'b0;
    @(negedge clk);
    run_op(32'h3333_3333, 32'hCCCC_CCCC, 1'b0, 50, lat);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_waitrequest();
    test_busy_ignore();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
